// File: rtl/edgegate_multi_pkg.sv
// Shared state encodings and gate decode for the multi-channel edge gate.
// Encoding 2'd3 is unnamed and decodes as IDLE everywhere.
`timescale 1ns/1ps
package edgegate_multi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BURST = 2'd2
    } chan_state_t;

    // RUN is only entered or held while en is sampled high, so the state itself
    // carries the registered enable; this keeps the pulse at the edge that samples en low.
    function automatic logic gate_for(chan_state_t s, logic cnt_nz);
        case (s)
            ST_RUN:   return 1'b1;
            ST_BURST: return cnt_nz;
            default:  return 1'b0;
        endcase
    endfunction

    function automatic logic busy_for(chan_state_t s);
        return (s == ST_RUN) || (s == ST_BURST);
    endfunction

endpackage

// File: rtl/edgegate_chan.sv
// One gated clock channel: rising-edge control FSM and burst counter, falling-edge
// gate register, and the output AND that only ever passes whole high phases.
`timescale 1ns/1ps
module edgegate_chan
    import edgegate_multi_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             go,
    input  logic             abort,
    input  logic [CNT_W-1:0] burst_len,
    output logic             clkout,
    output logic             busy,
    output logic             done
);

    chan_state_t      state_q;
    chan_state_t      state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             done_d;
    logic             gate_next;
    logic             gate_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        gate_next = gate_for(state_q, cnt_q != '0);
        case (state_q)
            ST_RUN: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else if (gate_q) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                // go outranks en and abort here; a zero-length go only reports done
                state_d = ST_IDLE;
                if (go) begin
                    if (burst_len != '0) begin
                        cnt_d   = burst_len;
                        state_d = ST_BURST;
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (en) begin
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy    <= busy_for(state_d);
            done    <= done_d;
        end
    end

    // Updating the gate while clk is low means the AND below never sees a partial high phase.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            gate_q <= 1'b0;
        end else begin
            gate_q <= gate_next;
        end
    end

    assign clkout = clk & gate_q;

endmodule

// File: rtl/edgegate_multi.sv
// Multi-channel glitch-free clock gate: independent run/halt/burst control per output,
// all channels sharing one burst length bus.
`timescale 1ns/1ps
module edgegate_multi
    import edgegate_multi_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] en,
    input  logic [CHANNELS-1:0] go,
    input  logic [CHANNELS-1:0] abort,
    input  logic [CNT_W-1:0]    burst_len,
    output logic [CHANNELS-1:0] clkout,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] done
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        edgegate_chan #(
            .CNT_W(CNT_W)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .en       (en[g]),
            .go       (go[g]),
            .abort    (abort[g]),
            .burst_len(burst_len),
            .clkout   (clkout[g]),
            .busy     (busy[g]),
            .done     (done[g])
        );
    end

endmodule
